// File: rtl/game_pkg.sv
// Shared types and widths for the game rules engine: FSM states and datapath widths.
package game_pkg;

    localparam int COORD_W = 10;
    localparam int DIST_W  = 21;
    localparam int SCORE_W = 16;
    localparam int LIVES_W = 3;
    localparam int FRAME_W = 10;
    localparam int CHAIN_W = 2;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [CHAIN_W-1:0] CHAIN_MAX = '1;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_POWER,
        ST_DYING,
        ST_OVER
    } game_state_e;

endpackage

// File: rtl/sq_distance.sv
// Combinational squared Euclidean distance between two screen points.
module sq_distance
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic [DIST_W-1:0]  dist2
);

    localparam int SQ_W = 2 * COORD_W;

    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic [COORD_W-1:0]      dx_abs;
    logic [COORD_W-1:0]      dy_abs;
    logic [SQ_W-1:0]         dx_sq;
    logic [SQ_W-1:0]         dy_sq;

    // Differences are taken one bit wider so a point left of/above the other never wraps.
    always_comb begin
        dx     = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy     = $signed({1'b0, ay}) - $signed({1'b0, by});
        dx_abs = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
        dy_abs = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];
        dx_sq  = SQ_W'(dx_abs) * SQ_W'(dx_abs);
        dy_sq  = SQ_W'(dy_abs) * SQ_W'(dy_abs);
        dist2  = DIST_W'(dx_sq) + DIST_W'(dy_sq);
    end

endmodule

// File: rtl/game_rules_engine.sv
// Per-frame game rules: collisions, lives, score, power mode and death/respawn sequencing.
module game_rules_engine
    import game_pkg::*;
#(
    parameter int N_GHOSTS     = 3,
    parameter int N_PELLETS    = 3,
    parameter int LIVES_INIT   = 3,
    parameter int POWER_FRAMES = 600,
    parameter int DEATH_FRAMES = 120,
    parameter int HIT_R2       = 64,
    parameter int GHOST_BONUS  = 10
) (
    input  logic                                frame_clk,
    input  logic                                Reset_h,
    input  logic [COORD_W-1:0]                  pacman_x,
    input  logic [COORD_W-1:0]                  pacman_y,
    input  logic [N_GHOSTS-1:0][COORD_W-1:0]    ghost_x,
    input  logic [N_GHOSTS-1:0][COORD_W-1:0]    ghost_y,
    input  logic [N_PELLETS-1:0][COORD_W-1:0]   pellet_x,
    input  logic [N_PELLETS-1:0][COORD_W-1:0]   pellet_y,
    input  logic                                dot_eaten,
    output logic [LIVES_W-1:0]                  lives,
    output logic [SCORE_W-1:0]                  score,
    output logic                                power_active,
    output logic [FRAME_W-1:0]                  power_left,
    output logic [N_GHOSTS-1:0]                 ghost_enable,
    output logic [N_PELLETS-1:0]                pellet_on,
    output logic                                respawn,
    output logic                                dying,
    output logic                                game_over
);

    localparam int SUM_W = SCORE_W + 2;

    game_state_e          state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [FRAME_W-1:0]   power_left_q, power_left_d;
    logic [FRAME_W-1:0]   death_cnt_q, death_cnt_d;
    logic [CHAIN_W-1:0]   chain_q, chain_d;
    logic [N_GHOSTS-1:0]  ghost_enable_q, ghost_enable_d;
    logic [N_PELLETS-1:0] pellet_on_q, pellet_on_d;
    logic                 respawn_q, respawn_d;
    logic                 power_active_q, dying_q, game_over_q;

    logic [DIST_W-1:0]    ghost_dist [N_GHOSTS];
    logic [DIST_W-1:0]    pellet_dist [N_PELLETS];
    logic [N_GHOSTS-1:0]  ghost_hit;
    logic [N_PELLETS-1:0] pellet_hit;
    logic [N_GHOSTS-1:0]  eat_onehot;
    logic [SCORE_W-1:0]   bonus;
    logic [SCORE_W-1:0]   add_bonus;
    logic                 add_dot;
    logic [SUM_W-1:0]     score_sum;

    for (genvar g = 0; g < N_GHOSTS; g++) begin : g_ghost
        sq_distance u_dist (
            .ax    (pacman_x),
            .ay    (pacman_y),
            .bx    (ghost_x[g]),
            .by    (ghost_y[g]),
            .dist2 (ghost_dist[g])
        );
        assign ghost_hit[g] = ghost_enable_q[g] && (ghost_dist[g] < DIST_W'(HIT_R2));
    end

    for (genvar p = 0; p < N_PELLETS; p++) begin : g_pellet
        sq_distance u_dist (
            .ax    (pacman_x),
            .ay    (pacman_y),
            .bx    (pellet_x[p]),
            .by    (pellet_y[p]),
            .dist2 (pellet_dist[p])
        );
        assign pellet_hit[p] = pellet_on_q[p] && (pellet_dist[p] < DIST_W'(HIT_R2));
    end

    // Only the lowest-index overlapping ghost is eaten in a given frame.
    assign eat_onehot = ghost_hit & (~ghost_hit + N_GHOSTS'(1));
    assign bonus      = SCORE_W'(GHOST_BONUS) << chain_q;

    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        power_left_d   = power_left_q;
        death_cnt_d    = death_cnt_q;
        chain_d        = chain_q;
        ghost_enable_d = ghost_enable_q;
        pellet_on_d    = pellet_on_q;
        respawn_d      = 1'b0;
        add_dot        = 1'b0;
        add_bonus      = '0;

        case (state_q)
            ST_PLAY: begin
                add_dot     = dot_eaten;
                pellet_on_d = pellet_on_q & ~pellet_hit;
                if (|ghost_hit) begin
                    state_d      = ST_DYING;
                    lives_d      = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                    death_cnt_d  = FRAME_W'(DEATH_FRAMES);
                    power_left_d = '0;
                    chain_d      = '0;
                end else if (|pellet_hit) begin
                    state_d      = ST_POWER;
                    power_left_d = FRAME_W'(POWER_FRAMES);
                    chain_d      = '0;
                end
            end
            ST_POWER: begin
                add_dot        = dot_eaten;
                pellet_on_d    = pellet_on_q & ~pellet_hit;
                ghost_enable_d = ghost_enable_q & ~eat_onehot;
                if (|ghost_hit) begin
                    add_bonus = bonus;
                    chain_d   = (chain_q == CHAIN_MAX) ? chain_q : chain_q + CHAIN_W'(1);
                end
                // A fresh pellet on the last power frame keeps power alive.
                if (|pellet_hit) begin
                    power_left_d = FRAME_W'(POWER_FRAMES);
                end else if (power_left_q == FRAME_W'(1)) begin
                    state_d        = ST_PLAY;
                    power_left_d   = '0;
                    ghost_enable_d = '1;
                end else begin
                    power_left_d = power_left_q - FRAME_W'(1);
                end
            end
            ST_DYING: begin
                if (death_cnt_q == '0) begin
                    if (lives_q == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d        = ST_PLAY;
                        respawn_d      = 1'b1;
                        ghost_enable_d = '1;
                    end
                end else begin
                    death_cnt_d = death_cnt_q - FRAME_W'(1);
                end
            end
            default: begin
            end
        endcase

        score_sum = SUM_W'(score_q) + SUM_W'(add_dot) + SUM_W'(add_bonus);
        score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge frame_clk or posedge Reset_h) begin
        if (Reset_h) begin
            state_q        <= ST_PLAY;
            lives_q        <= LIVES_W'(LIVES_INIT);
            score_q        <= '0;
            power_left_q   <= '0;
            death_cnt_q    <= '0;
            chain_q        <= '0;
            ghost_enable_q <= '1;
            pellet_on_q    <= '1;
            respawn_q      <= 1'b0;
            power_active_q <= 1'b0;
            dying_q        <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            power_left_q   <= power_left_d;
            death_cnt_q    <= death_cnt_d;
            chain_q        <= chain_d;
            ghost_enable_q <= ghost_enable_d;
            pellet_on_q    <= pellet_on_d;
            respawn_q      <= respawn_d;
            power_active_q <= (state_d == ST_POWER);
            dying_q        <= (state_d == ST_DYING);
            game_over_q    <= (state_d == ST_OVER);
        end
    end

    assign lives        = lives_q;
    assign score        = score_q;
    assign power_active = power_active_q;
    assign power_left   = power_left_q;
    assign ghost_enable = ghost_enable_q;
    assign pellet_on    = pellet_on_q;
    assign respawn      = respawn_q;
    assign dying        = dying_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_rules_engine.sv
// Directed bench for game_rules_engine; a second instance with a large ghost bonus exercises score saturation.
module tb_game_rules_engine;

    localparam int NG = 5;
    localparam int NP = 3;

    logic                   frame_clk = 1'b0;
    logic                   Reset_h;
    logic [9:0]             pacman_x, pacman_y;
    logic [NG-1:0][9:0]     ghost_x, ghost_y;
    logic [NP-1:0][9:0]     pellet_x, pellet_y;
    logic                   dot_eaten;

    logic [2:0]    lives, sat_lives;
    logic [15:0]   score, sat_score;
    logic          power_active, sat_power_active;
    logic [9:0]    power_left, sat_power_left;
    logic [NG-1:0] ghost_enable, sat_ghost_enable;
    logic [NP-1:0] pellet_on, sat_pellet_on;
    logic          respawn, sat_respawn;
    logic          dying, sat_dying;
    logic          game_over, sat_game_over;

    int checks = 0;
    int passed = 0;

    always #5 frame_clk = ~frame_clk;

    game_rules_engine #(.N_GHOSTS(NG), .N_PELLETS(NP)) dut (
        .frame_clk(frame_clk), .Reset_h(Reset_h),
        .pacman_x(pacman_x), .pacman_y(pacman_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pellet_x(pellet_x), .pellet_y(pellet_y),
        .dot_eaten(dot_eaten),
        .lives(lives), .score(score), .power_active(power_active),
        .power_left(power_left), .ghost_enable(ghost_enable),
        .pellet_on(pellet_on), .respawn(respawn), .dying(dying),
        .game_over(game_over)
    );

    game_rules_engine #(.N_GHOSTS(NG), .N_PELLETS(NP), .GHOST_BONUS(9361)) dut_sat (
        .frame_clk(frame_clk), .Reset_h(Reset_h),
        .pacman_x(pacman_x), .pacman_y(pacman_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pellet_x(pellet_x), .pellet_y(pellet_y),
        .dot_eaten(dot_eaten),
        .lives(sat_lives), .score(sat_score), .power_active(sat_power_active),
        .power_left(sat_power_left), .ghost_enable(sat_ghost_enable),
        .pellet_on(sat_pellet_on), .respawn(sat_respawn), .dying(sat_dying),
        .game_over(sat_game_over)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic park_ghosts();
        for (int g = 0; g < NG; g++) begin
            ghost_x[g] = 10'd900;
            ghost_y[g] = 10'(40 + g * 100);
        end
    endtask

    task automatic do_reset();
        @(posedge frame_clk);
        #1;
        Reset_h   = 1'b1;
        dot_eaten = 1'b0;
        pacman_x  = 10'd100;
        pacman_y  = 10'd100;
        park_ghosts();
        tick(2);
        Reset_h = 1'b0;
        tick(1);
    endtask

    task automatic lose_life();
        ghost_x[0] = pacman_x;
        ghost_y[0] = pacman_y;
        tick(1);
        park_ghosts();
        tick(121);
    endtask

    task automatic test_reset();
        Reset_h   = 1'b0;
        dot_eaten = 1'b0;
        pacman_x  = 10'd100;
        pacman_y  = 10'd100;
        park_ghosts();
        pellet_x[0] = 10'd40;  pellet_y[0] = 10'd440;
        pellet_x[1] = 10'd208; pellet_y[1] = 10'd256;
        pellet_x[2] = 10'd560; pellet_y[2] = 10'd440;
        #2 Reset_h = 1'b1;
        #1;
        checks++; if (lives !== 3'd3) $display("FAIL reset_lives: got %0d want 3", lives); else passed++;
        checks++; if (score !== 16'd0) $display("FAIL reset_score: got %0d want 0", score); else passed++;
        checks++; if (power_active !== 1'b0) $display("FAIL reset_power_active: got %b want 0", power_active); else passed++;
        checks++; if (power_left !== 10'd0) $display("FAIL reset_power_left: got %0d want 0", power_left); else passed++;
        checks++; if (ghost_enable !== 5'b11111) $display("FAIL reset_ghost_enable: got %b want 11111", ghost_enable); else passed++;
        checks++; if (pellet_on !== 3'b111) $display("FAIL reset_pellet_on: got %b want 111", pellet_on); else passed++;
        checks++; if (respawn !== 1'b0) $display("FAIL reset_respawn: got %b want 0", respawn); else passed++;
        checks++; if (dying !== 1'b0 || game_over !== 1'b0) $display("FAIL reset_flags: got dying=%b over=%b want 0 0", dying, game_over); else passed++;
        tick(2);
        Reset_h = 1'b0;
        tick(1);
        dot_eaten = 1'b1;
        tick(3);
        dot_eaten = 1'b0;
        tick(1);
        checks++; if (score !== 16'd3) $display("FAIL dot_score: got %0d want 3", score); else passed++;
    endtask

    task automatic test_boundary();
        do_reset();
        pacman_x = 10'd200; pacman_y = 10'd256;
        tick(1);
        checks++; if (power_active !== 1'b0 || pellet_on !== 3'b111) $display("FAIL pellet_r2_edge: got power=%b pellets=%b want 0 111", power_active, pellet_on); else passed++;
        pacman_x = 10'd2; pacman_y = 10'd2;
        ghost_x[0] = 10'd1020; ghost_y[0] = 10'd2;
        tick(1);
        checks++; if (dying !== 1'b0) $display("FAIL no_wrap: got dying=%b want 0", dying); else passed++;
        park_ghosts();
        pacman_x = 10'd200; pacman_y = 10'd200;
        ghost_x[1] = 10'd208; ghost_y[1] = 10'd200;
        tick(1);
        checks++; if (dying !== 1'b0) $display("FAIL ghost_r2_edge: got dying=%b want 0", dying); else passed++;
        ghost_x[1] = 10'd194; ghost_y[1] = 10'd195;
        tick(1);
        checks++; if (dying !== 1'b1 || lives !== 3'd2) $display("FAIL ghost_negative_hit: got dying=%b lives=%0d want 1 2", dying, lives); else passed++;
    endtask

    task automatic test_death_respawn();
        do_reset();
        pacman_x = 10'd200; pacman_y = 10'd200;
        ghost_x[0] = 10'd204; ghost_y[0] = 10'd204;
        tick(1);
        checks++; if (dying !== 1'b1) $display("FAIL death_enter: got dying=%b want 1", dying); else passed++;
        checks++; if (lives !== 3'd2) $display("FAIL death_lives: got %0d want 2", lives); else passed++;
        park_ghosts();
        tick(120);
        checks++; if (dying !== 1'b1 || respawn !== 1'b0) $display("FAIL death_hold: got dying=%b respawn=%b want 1 0", dying, respawn); else passed++;
        tick(1);
        checks++; if (respawn !== 1'b1 || dying !== 1'b0) $display("FAIL respawn_pulse: got respawn=%b dying=%b want 1 0", respawn, dying); else passed++;
        checks++; if (ghost_enable !== 5'b11111) $display("FAIL respawn_ghosts: got %b want 11111", ghost_enable); else passed++;
        tick(1);
        checks++; if (respawn !== 1'b0) $display("FAIL respawn_one_frame: got %b want 0", respawn); else passed++;
    endtask

    task automatic test_power();
        do_reset();
        pacman_x = 10'd208; pacman_y = 10'd256;
        tick(1);
        checks++; if (power_active !== 1'b1 || power_left !== 10'd600) $display("FAIL power_enter: got power=%b left=%0d want 1 600", power_active, power_left); else passed++;
        checks++; if (pellet_on !== 3'b101) $display("FAIL power_pellet: got %b want 101", pellet_on); else passed++;
        pacman_x = 10'd100; pacman_y = 10'd100;
        ghost_x[1] = 10'd100; ghost_y[1] = 10'd100;
        tick(1);
        checks++; if (ghost_enable !== 5'b11101 || score !== 16'd10) $display("FAIL power_eat: got en=%b score=%0d want 11101 10", ghost_enable, score); else passed++;
        checks++; if (power_left !== 10'd599) $display("FAIL power_count: got %0d want 599", power_left); else passed++;
        park_ghosts();
        tick(9);
        pacman_x = 10'd40; pacman_y = 10'd440;
        tick(1);
        checks++; if (power_left !== 10'd600 || pellet_on !== 3'b100) $display("FAIL power_reload: got left=%0d pellets=%b want 600 100", power_left, pellet_on); else passed++;
        pacman_x = 10'd100; pacman_y = 10'd100;
        ghost_x[2] = 10'd100; ghost_y[2] = 10'd100;
        tick(1);
        checks++; if (score !== 16'd30 || ghost_enable !== 5'b11001) $display("FAIL chain_kept: got score=%0d en=%b want 30 11001", score, ghost_enable); else passed++;
        park_ghosts();
        tick(598);
        checks++; if (power_active !== 1'b1 || power_left !== 10'd1) $display("FAIL power_last: got power=%b left=%0d want 1 1", power_active, power_left); else passed++;
        tick(1);
        checks++; if (power_active !== 1'b0 || power_left !== 10'd0) $display("FAIL power_expire: got power=%b left=%0d want 0 0", power_active, power_left); else passed++;
        checks++; if (ghost_enable !== 5'b11111) $display("FAIL power_reenable: got %b want 11111", ghost_enable); else passed++;
    endtask

    task automatic test_chain();
        do_reset();
        pacman_x = 10'd208; pacman_y = 10'd256;
        tick(1);
        pacman_x = 10'd300; pacman_y = 10'd300;
        ghost_x[0] = 10'd300; ghost_y[0] = 10'd300;
        ghost_x[2] = 10'd300; ghost_y[2] = 10'd300;
        tick(1);
        checks++; if (ghost_enable !== 5'b11110 || score !== 16'd10) $display("FAIL chain_first: got en=%b score=%0d want 11110 10", ghost_enable, score); else passed++;
        tick(1);
        checks++; if (ghost_enable !== 5'b11010 || score !== 16'd30) $display("FAIL chain_second: got en=%b score=%0d want 11010 30", ghost_enable, score); else passed++;
        ghost_x[1] = 10'd300; ghost_y[1] = 10'd300;
        tick(1);
        checks++; if (score !== 16'd70) $display("FAIL chain_third: got %0d want 70", score); else passed++;
        ghost_x[3] = 10'd300; ghost_y[3] = 10'd300;
        tick(1);
        checks++; if (score !== 16'd150) $display("FAIL chain_fourth: got %0d want 150", score); else passed++;
        ghost_x[4] = 10'd300; ghost_y[4] = 10'd300;
        tick(1);
        checks++; if (score !== 16'd230 || ghost_enable !== 5'b00000) $display("FAIL chain_fifth: got score=%0d en=%b want 230 00000", score, ghost_enable); else passed++;
        tick(1);
        checks++; if (score !== 16'd230) $display("FAIL chain_none_left: got %0d want 230", score); else passed++;
        #3 Reset_h = 1'b1;
        #1;
        checks++; if (power_active !== 1'b0 || power_left !== 10'd0 || ghost_enable !== 5'b11111) $display("FAIL async_reset_power: got power=%b left=%0d en=%b want 0 0 11111", power_active, power_left, ghost_enable); else passed++;
        tick(1);
        Reset_h = 1'b0;
        park_ghosts();
    endtask

    task automatic test_pellet_and_ghost();
        do_reset();
        pacman_x = 10'd208; pacman_y = 10'd256;
        ghost_x[0] = 10'd210; ghost_y[0] = 10'd256;
        tick(1);
        checks++; if (dying !== 1'b1 || lives !== 3'd2) $display("FAIL both_dying: got dying=%b lives=%0d want 1 2", dying, lives); else passed++;
        checks++; if (pellet_on !== 3'b101) $display("FAIL both_pellet: got %b want 101", pellet_on); else passed++;
        checks++; if (power_active !== 1'b0 || power_left !== 10'd0) $display("FAIL both_no_power: got power=%b left=%0d want 0 0", power_active, power_left); else passed++;
    endtask

    task automatic test_game_over();
        do_reset();
        lose_life();
        lose_life();
        checks++; if (lives !== 3'd1 || dying !== 1'b0) $display("FAIL over_setup: got lives=%0d dying=%b want 1 0", lives, dying); else passed++;
        ghost_x[0] = pacman_x; ghost_y[0] = pacman_y;
        tick(1);
        park_ghosts();
        checks++; if (dying !== 1'b1 || lives !== 3'd0) $display("FAIL last_death: got dying=%b lives=%0d want 1 0", dying, lives); else passed++;
        dot_eaten = 1'b1;
        tick(120);
        checks++; if (dying !== 1'b1 || score !== 16'd0) $display("FAIL dying_dots: got dying=%b score=%0d want 1 0", dying, score); else passed++;
        tick(1);
        checks++; if (game_over !== 1'b1 || dying !== 1'b0 || respawn !== 1'b0) $display("FAIL over_enter: got over=%b dying=%b respawn=%b want 1 0 0", game_over, dying, respawn); else passed++;
        pacman_x = 10'd208; pacman_y = 10'd256;
        ghost_x[0] = 10'd208; ghost_y[0] = 10'd256;
        tick(3);
        checks++; if (score !== 16'd0 || lives !== 3'd0 || pellet_on !== 3'b111) $display("FAIL over_absorb: got score=%0d lives=%0d pellets=%b want 0 0 111", score, lives, pellet_on); else passed++;
        checks++; if (game_over !== 1'b1) $display("FAIL over_stays: got %b want 1", game_over); else passed++;
        dot_eaten = 1'b0;
        #3 Reset_h = 1'b1;
        #1;
        checks++; if (lives !== 3'd3 || score !== 16'd0 || game_over !== 1'b0) $display("FAIL over_reset: got lives=%0d score=%0d over=%b want 3 0 0", lives, score, game_over); else passed++;
        tick(1);
        Reset_h = 1'b0;
        park_ghosts();
    endtask

    task automatic test_saturation();
        do_reset();
        dot_eaten = 1'b1;
        tick(1);
        dot_eaten = 1'b0;
        pacman_x = 10'd208; pacman_y = 10'd256;
        tick(1);
        pacman_x = 10'd300; pacman_y = 10'd300;
        for (int g = 0; g < 3; g++) begin
            ghost_x[g] = 10'd300; ghost_y[g] = 10'd300;
            tick(1);
        end
        checks++; if (sat_score !== 16'hFFF8) $display("FAIL sat_setup: got %h want fff8", sat_score); else passed++;
        checks++; if (score !== 16'd71) $display("FAIL sat_main_setup: got %0d want 71", score); else passed++;
        park_ghosts();
        tick(597);
        checks++; if (sat_power_active !== 1'b0) $display("FAIL sat_power_end: got %b want 0", sat_power_active); else passed++;
        pacman_x = 10'd560; pacman_y = 10'd440;
        tick(1);
        ghost_x[3] = 10'd560; ghost_y[3] = 10'd440;
        dot_eaten = 1'b1;
        tick(1);
        checks++; if (sat_score !== 16'hFFFF) $display("FAIL sat_clamp: got %h want ffff", sat_score); else passed++;
        checks++; if (score !== 16'd82) $display("FAIL sat_main_bonus_dot: got %0d want 82", score); else passed++;
        tick(1);
        dot_eaten = 1'b0;
        checks++; if (sat_score !== 16'hFFFF || score !== 16'd83) $display("FAIL sat_hold: got sat=%h main=%0d want ffff 83", sat_score, score); else passed++;
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_death_respawn();
        test_power();
        test_chain();
        test_pellet_and_ghost();
        test_game_over();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/game_rules_engine.md
GAME_RULES_ENGINE -- requirements
Module: game_rules_engine

Interface
REQ-001 Parameter N_GHOSTS, default 3, number of ghost channels (1..8).
REQ-002 Parameter N_PELLETS, default 3, number of power pellets (1..8).
REQ-003 Parameter LIVES_INIT, default 3, lives loaded at reset (1..7).
REQ-004 Parameter POWER_FRAMES, default 600, power-mode duration in frames.
REQ-005 Parameter DEATH_FRAMES, default 120, death-animation hold in frames.
REQ-006 Parameter HIT_R2, default 64, collision threshold on squared distance (strict less-than).
REQ-007 Parameter GHOST_BONUS, default 10, base score for first ghost eaten per power period.
REQ-008 frame_clk  in  1  frame-rate clock (VGA vertical sync); all state updates on its rising edge.
REQ-009 Reset_h  in  1  reset, asynchronous, active-high.
REQ-010 pacman_x, pacman_y  in  10 each  pacman centre, pixels.
REQ-011 ghost_x, ghost_y  in  N_GHOSTS x 10  ghost centres.
REQ-012 pellet_x, pellet_y  in  N_PELLETS x 10  pellet centres (static).
REQ-013 dot_eaten  in  1  one-frame strobe from the dot map: pacman consumed a dot.
REQ-014 lives  out  3  remaining lives.
REQ-015 score  out  16  saturating score.
REQ-016 power_active  out  1  high in POWER state (drives ghost reversal).
REQ-017 power_left  out  10  frames remaining in POWER, 0 otherwise.
REQ-018 ghost_enable  out  N_GHOSTS  ghost is live/drawn.
REQ-019 pellet_on  out  N_PELLETS  pellet not yet consumed.
REQ-020 respawn  out  1  one-frame pulse on DYING->PLAY; sprite modules return to start positions.
REQ-021 dying, game_over  out  1 each  state decodes.

Function
REQ-022 Per-channel squared distance SHALL use signed 11-bit differences and a 21-bit unsigned sum; no wrap on negative offsets.
REQ-023 Hit(g) = ghost_enable[g] and dist2(g) < HIT_R2; pellet hit(p) = pellet_on[p] and dist2(p) < HIT_R2.
REQ-024 FSM states PLAY, POWER, DYING, OVER; reset state PLAY.
REQ-025 PLAY: any ghost hit -> DYING, lives decremented (floor 0), death counter loaded DEATH_FRAMES; ghost hit outranks pellet hit in the same frame.
REQ-026 PLAY: pellet hit without ghost hit -> POWER, power_left = POWER_FRAMES, bonus chain = 0.
REQ-027 Any pellet hit in PLAY or POWER SHALL clear that pellet_on bit, even when the ghost hit wins.
REQ-028 POWER: lowest-index ghost hit only is eaten per frame: ghost_enable bit cleared, score += GHOST_BONUS << chain, chain increments saturating at 3.
REQ-029 POWER: pellet hit reloads power_left to POWER_FRAMES; chain unchanged.
REQ-030 POWER: power_left decrements each frame; on the frame it is 1, next state PLAY, power_left 0, all ghost_enable bits set.
REQ-031 DYING: counter decrements each frame; at 0, lives == 0 -> OVER, else PLAY with respawn pulse, all ghost_enable set; power cancelled on entry.
REQ-032 OVER: absorbing until reset; no score, lives or pellet changes.
REQ-033 dot_eaten adds 1 to score in PLAY and POWER only; ignored in DYING and OVER.
REQ-034 Dot and ghost bonus in the same frame SHALL both be added; score saturates at 16'hFFFF.
REQ-035 All outputs registered; response visible one frame_clk edge after the inputs that cause it.

Reset
REQ-036 On Reset_h: state PLAY, lives = LIVES_INIT, score 0, power_left 0, chain 0, ghost_enable all 1, pellet_on all 1, respawn 0, counters 0.
REQ-037 Reset mid-POWER or mid-DYING SHALL take effect immediately and asynchronously.

Structure
REQ-038 Package game_pkg SHALL hold the state enum, coordinate width (10), distance width (21) and score width (16).
REQ-039 One sub-module sq_distance (two points in, 21-bit squared distance out, combinational), instantiated N_GHOSTS + N_PELLETS times.

Verification
REQ-040 Pacman (200,200), ghost0 (204,204), dist2 32 -> next frame DYING, lives 3->2; after 120 frames respawn pulse, PLAY.
REQ-041 Pacman on pellet1 (208,256) -> POWER, power_left 600, pellet_on = 3'b101; 600 frames later PLAY, ghosts re-enabled.
REQ-042 POWER, ghosts 0 and 2 overlap same frame -> ghost0 eaten (+10), next frame ghost2 eaten (+20); fourth and fifth eats +80 each.
REQ-043 Pellet and enabled ghost hit same frame in PLAY -> DYING, pellet cleared, no power.
REQ-044 lives 1, ghost hit -> DYING, then OVER; dot_eaten pulses ignored; Reset_h mid-OVER restores lives 3, score 0.
REQ-045 score 16'hFFF8, POWER with chain 0, ghost eaten and dot_eaten same frame -> score 16'hFFFF.
